// File: rtl/one_wire_rom_reader.sv
// 1-Wire bus master front end for reading a device ROM code.
// It runs the reset/presence sequence and sends the Read ROM command LSB first.
// It then reads 64 bits in standard-speed read slots.
// Each received bit is streamed out with a strobe and also latched into rom_id.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         single-cycle request, accepted only while idle
//   ow_in         raw bus level (asynchronous, synchronised internally)
//   ow_drive_low  registered open-drain pull-down control (1 = pull low)
//   busy          transaction in progress
//   done          one-cycle pulse when a transaction ends (success or error)
//   no_presence   sticky error flag, cleared by the next accepted start
//   frame_start   one-cycle pulse immediately before the first bit_valid
//   bit_data      received bit, qualified by bit_valid
//   bit_valid     one-cycle strobe per received bit (64 per frame)
//   rom_id        received ROM code; bit i is the i-th received bit
//   rom_valid     set after a successful read, cleared by an accepted start
module one_wire_rom_reader #(
  parameter int unsigned TICKS_PER_US = 50,
  parameter logic [7:0]  ROM_CMD      = 8'h33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ow_in,
  output logic        ow_drive_low,
  output logic        busy,
  output logic        done,
  output logic        no_presence,
  output logic        frame_start,
  output logic        bit_data,
  output logic        bit_valid,
  output logic [63:0] rom_id,
  output logic        rom_valid
);

  localparam int unsigned T_RST  = 480 * TICKS_PER_US;
  localparam int unsigned T_SLOT = 70 * TICKS_PER_US;
  localparam int unsigned T_LOW1 = 6 * TICKS_PER_US;
  localparam int unsigned T_LOW0 = 60 * TICKS_PER_US;
  localparam int unsigned T_PRES = 70 * TICKS_PER_US;
  localparam int unsigned T_SAMP = 15 * TICKS_PER_US;
  localparam int unsigned TW     = $clog2(T_RST + 1);

  // The timer is loaded with (duration - 1) and counts down to zero.
  // An event at elapsed tick E therefore fires when timer == duration - 1 - E.
  localparam logic [TW-1:0] TM_RST_LOAD  = TW'(T_RST - 1);
  localparam logic [TW-1:0] TM_SLOT_LOAD = TW'(T_SLOT - 1);
  localparam logic [TW-1:0] TM_PRES_SMP  = TW'(T_RST - 1 - T_PRES);
  localparam logic [TW-1:0] TM_RD_SMP    = TW'(T_SLOT - 1 - T_SAMP);
  localparam logic [TW-1:0] TM_FRAME     = TW'(T_SLOT - T_SAMP);
  // The bus is held low while the next timer value is at or above these thresholds.
  localparam logic [TW-1:0] TM_REL1      = TW'(T_SLOT - T_LOW1);
  localparam logic [TW-1:0] TM_REL0      = TW'(T_SLOT - T_LOW0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST_LOW   = 3'd1;
  localparam logic [2:0] S_RST_WAIT  = 3'd2;
  localparam logic [2:0] S_CMD_SLOT  = 3'd3;
  localparam logic [2:0] S_READ_SLOT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [5:0]    r_bit_idx;
  logic [2:0]    r_cmd_idx;
  logic          r_presence;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_drive;
  logic          r_busy;
  logic          r_done;
  logic          r_no_presence;
  logic          r_frame_start;
  logic          r_bit_data;
  logic          r_bit_valid;
  logic [63:0]   r_rom_id;
  logic          r_rom_valid;

  logic [2:0]    w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_timer_end;
  logic [5:0]    w_bit_idx_nxt;
  logic [2:0]    w_cmd_idx_nxt;
  logic          w_presence_nxt;
  logic          w_drive_nxt;
  logic          w_done_nxt;
  logic          w_no_presence_nxt;
  logic          w_frame_start_nxt;
  logic          w_bit_data_nxt;
  logic          w_bit_valid_nxt;
  logic [63:0]   w_rom_id_nxt;
  logic          w_rom_valid_nxt;

  // Two-flop synchroniser for the asynchronous bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ow_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic, timer, and next values of all registered outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_end       = (r_timer == '0);
    w_timer_nxt       = w_timer_end ? r_timer : r_timer - TW'(1);
    w_bit_idx_nxt     = r_bit_idx;
    w_cmd_idx_nxt     = r_cmd_idx;
    w_presence_nxt    = r_presence;
    w_drive_nxt       = 1'b0;
    w_done_nxt        = 1'b0;
    w_no_presence_nxt = r_no_presence;
    w_frame_start_nxt = 1'b0;
    w_bit_data_nxt    = r_bit_data;
    w_bit_valid_nxt   = 1'b0;
    w_rom_id_nxt      = r_rom_id;
    w_rom_valid_nxt   = r_rom_valid;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_no_presence_nxt = 1'b0;
          w_rom_valid_nxt   = 1'b0;
          w_timer_nxt       = TM_RST_LOAD;
          w_state_nxt       = S_RST_LOW;
        end
      end
      S_RST_LOW: begin
        if (w_timer_end) begin
          w_presence_nxt = 1'b0;
          w_timer_nxt    = TM_RST_LOAD;
          w_state_nxt    = S_RST_WAIT;
        end
      end
      S_RST_WAIT: begin
        if (r_timer == TM_PRES_SMP) begin
          w_presence_nxt = ~r_sync2;
        end
        if (w_timer_end) begin
          if (r_presence) begin
            w_cmd_idx_nxt = 3'd0;
            w_timer_nxt   = TM_SLOT_LOAD;
            w_state_nxt   = S_CMD_SLOT;
          end else begin
            w_no_presence_nxt = 1'b1;
            w_done_nxt        = 1'b1;
            w_state_nxt       = S_IDLE;
          end
        end
      end
      S_CMD_SLOT: begin
        if (w_timer_end) begin
          w_timer_nxt = TM_SLOT_LOAD;
          if (r_cmd_idx == 3'd7) begin
            w_bit_idx_nxt = 6'd0;
            w_state_nxt   = S_READ_SLOT;
          end else begin
            w_cmd_idx_nxt = r_cmd_idx + 3'd1;
          end
        end
      end
      S_READ_SLOT: begin
        // frame_start lands in the sampling cycle of bit 0, one cycle before its strobe.
        if ((r_bit_idx == 6'd0) && (r_timer == TM_FRAME)) begin
          w_frame_start_nxt = 1'b1;
        end
        if (r_timer == TM_RD_SMP) begin
          w_bit_valid_nxt         = 1'b1;
          w_bit_data_nxt          = r_sync2;
          w_rom_id_nxt[r_bit_idx] = r_sync2;
        end
        if (w_timer_end) begin
          if (r_bit_idx == 6'd63) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 6'd1;
            w_timer_nxt   = TM_SLOT_LOAD;
          end
        end
      end
      S_DONE: begin
        w_done_nxt      = 1'b1;
        w_rom_valid_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pad drive follows the state and timer being entered, so the register is glitch-free.
    case (w_state_nxt)
      S_RST_LOW:   w_drive_nxt = 1'b1;
      S_CMD_SLOT:  w_drive_nxt = ROM_CMD[w_cmd_idx_nxt] ? (w_timer_nxt >= TM_REL1)
                                                        : (w_timer_nxt >= TM_REL0);
      S_READ_SLOT: w_drive_nxt = (w_timer_nxt >= TM_REL1);
      default:     w_drive_nxt = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_bit_idx     <= 6'd0;
      r_cmd_idx     <= 3'd0;
      r_presence    <= 1'b0;
      r_drive       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_no_presence <= 1'b0;
      r_frame_start <= 1'b0;
      r_bit_data    <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_rom_id      <= 64'd0;
      r_rom_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_cmd_idx     <= w_cmd_idx_nxt;
      r_presence    <= w_presence_nxt;
      r_drive       <= w_drive_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_no_presence <= w_no_presence_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_bit_data    <= w_bit_data_nxt;
      r_bit_valid   <= w_bit_valid_nxt;
      r_rom_id      <= w_rom_id_nxt;
      r_rom_valid   <= w_rom_valid_nxt;
    end
  end

  assign ow_drive_low = r_drive;
  assign busy         = r_busy;
  assign done         = r_done;
  assign no_presence  = r_no_presence;
  assign frame_start  = r_frame_start;
  assign bit_data     = r_bit_data;
  assign bit_valid    = r_bit_valid;
  assign rom_id       = r_rom_id;
  assign rom_valid    = r_rom_valid;

endmodule
